alu_seq: RTL and testbench

Parametrised, handshaked successor to the 40-bit single-cycle ALU. It keeps the existing 5-bit opcode encoding and adds a true multiply and divide, variable shift amounts, status flags and valid/ready flow control. Single-cycle ops complete in one clock; multiply and divide run on an iterative unit over WIDTH cycles. It sits between an operand/command source and a result consumer, either of which may stall.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_iter.sv | 89 ++++++++
 rtl/alu_seq.sv | 134 +++++++++++++
 tb/tb_alu_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and flag bit positions for alu_seq.
package alu_pkg;

  localparam logic [4:0] OP_ADD    = 5'b00101;
  localparam logic [4:0] OP_ADDABS = 5'b00111;
  localparam logic [4:0] OP_SUB    = 5'b00110;
  localparam logic [4:0] OP_MUL    = 5'b01000;
  localparam logic [4:0] OP_DIV    = 5'b01011;
  localparam logic [4:0] OP_SHL    = 5'b01100;
  localparam logic [4:0] OP_SHR    = 5'b10100;
  localparam logic [4:0] OP_SRA    = 5'b10101;

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } state_e;

  // flags = {err, ovf, carry, zero}
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_ERR   = 3;

endpackage

// File: rtl/alu_iter.sv
// Iterative shift-add multiplier / restoring divider; one step per cycle, WIDTH steps.
// hi_q holds the partial product or remainder, lo_q the multiplier or developing quotient.
module alu_iter #(
  parameter int WIDTH = 40
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             div_mode_i,
  input  logic             run_i,
  input  logic             stall_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] res_o,
  output logic             ovf_o
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             div_q, div_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH:0]   mul_sum, div_shift, div_trial;
  logic [WIDTH-1:0] hi_step, lo_step;
  logic             adv;

  // The last step is withheld while the previous result is still unconsumed.
  assign adv    = run_i && !((cnt_q == '0) && stall_i);
  assign done_o = adv && (cnt_q == '0);
  assign res_o  = lo_step;
  assign ovf_o  = !div_q && (hi_step != '0);

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    if (div_q) begin
      if (div_trial[WIDTH]) begin
        hi_step = div_shift[WIDTH-1:0];
        lo_step = {lo_q[WIDTH-2:0], 1'b0};
      end else begin
        hi_step = div_trial[WIDTH-1:0];
        lo_step = {lo_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      hi_step = mul_sum[WIDTH:1];
      lo_step = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    opnd_d = opnd_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (start_i) begin
      cnt_d  = CW'(WIDTH - 1);
      div_d  = div_mode_i;
      hi_d   = '0;
      opnd_d = div_mode_i ? b_i : a_i;
      lo_d   = div_mode_i ? a_i : b_i;
    end else if (adv) begin
      hi_d = hi_step;
      lo_d = lo_step;
      if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      div_q  <= 1'b0;
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      opnd_q <= opnd_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops finish at acceptance, MUL/DIV run on alu_iter.
// in_valid/in_ready and out_valid/out_ready transfer on a clock edge where both are high.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 40,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output state_e           state_o
);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;

  logic             accept, iter_op, sc_done, it_done, it_ovf;
  logic [WIDTH-1:0] it_res, sc_res, b_abs, fin_res;
  logic [WIDTH:0]   add_w, sub_w;
  logic             sc_err, sc_ovf, sc_carry;
  logic [3:0]       fin_flags;

  assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign iter_op   = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
  assign sc_done   = accept && !iter_op;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
  assign state_o   = state_q;

  alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (accept && iter_op),
    .div_mode_i (op == OP_DIV),
    .run_i      (state_q == ITER),
    .stall_i    (out_valid_q && !out_ready),
    .a_i        (a),
    .b_i        (b),
    .done_o     (it_done),
    .res_o      (it_res),
    .ovf_o      (it_ovf)
  );

  always_comb begin
    add_w    = {1'b0, a} + {1'b0, b};
    sub_w    = {1'b0, a} - {1'b0, b};
    b_abs    = b[WIDTH-1] ? -b : b;
    sc_res   = '0;
    sc_err   = 1'b0;
    sc_ovf   = 1'b0;
    sc_carry = 1'b0;
    case (op)
      OP_ADD: begin
        sc_res   = add_w[WIDTH-1:0];
        sc_carry = add_w[WIDTH];
      end
      OP_ADDABS: begin
        sc_res = a + b_abs;
        sc_ovf = b[WIDTH-1] && (b[WIDTH-2:0] == '0);
      end
      OP_SUB: begin
        sc_res   = sub_w[WIDTH-1:0];
        sc_carry = sub_w[WIDTH];
      end
      OP_MUL: sc_res = '0;
      // Only the divide-by-zero case takes the single-cycle path.
      OP_DIV: begin
        sc_res = '1;
        sc_err = 1'b1;
      end
      OP_SHL:  sc_res = a << shamt;
      OP_SHR:  sc_res = a >> shamt;
      OP_SRA:  sc_res = $signed(a) >>> shamt;
      default: sc_err = 1'b1;
    endcase
  end

  always_comb begin
    fin_res              = sc_done ? sc_res : it_res;
    fin_flags            = '0;
    fin_flags[FLAG_ERR]  = sc_done && sc_err;
    fin_flags[FLAG_OVF]  = sc_done ? sc_ovf : it_ovf;
    fin_flags[FLAG_CARRY] = sc_done && sc_carry;
    fin_flags[FLAG_ZERO] = (fin_res == '0);

    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;

    if (state_q == IDLE) begin
      if (accept && iter_op) state_d = ITER;
    end else if (it_done) begin
      state_d = IDLE;
    end

    if (sc_done || it_done) begin
      out_valid_d = 1'b1;
      result_d    = fin_res;
      flags_d     = fin_flags;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, back-pressure and reset sequences, random ops vs model.
module tb_alu_seq;

  localparam int W  = 40;
  localparam int SW = 6;
  localparam logic [4:0] C_ADD = 5'b00101;
  localparam logic [4:0] C_ABS = 5'b00111;
  localparam logic [4:0] C_SUB = 5'b00110;
  localparam logic [4:0] C_MUL = 5'b01000;
  localparam logic [4:0] C_DIV = 5'b01011;
  localparam logic [4:0] C_SHL = 5'b01100;
  localparam logic [4:0] C_SHR = 5'b10100;
  localparam logic [4:0] C_SRA = 5'b10101;
  localparam longint unsigned MASK = (64'd1 << W) - 64'd1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4:0]    op = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [SW-1:0] shamt = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  result;
  logic [3:0]    flags;
  alu_pkg::state_e dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [3:0]   exp_f_q[$];

  typedef struct {
    logic [4:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [SW-1:0] sh;
    logic [W-1:0]  r;
    logic [3:0]    f;
    int            lat;
  } vec_t;
  vec_t tbl[18];

  alu_seq #(.WIDTH(W), .SHW(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .state_o   (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour from plain integer arithmetic.
  function automatic void model(input logic [4:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                                input logic [SW-1:0] sh, output logic [W-1:0] r, output logic [3:0] f);
    longint unsigned ua, ub, t, mag;
    longint          sa, sb;
    logic [2*W-1:0]  prod;
    bit              err, ovf, cy;
    ua = av; ub = bv; t = 0; err = 0; ovf = 0; cy = 0;
    sa = ((ua >> (W-1)) != 0) ? longint'(ua) - (longint'(1) << W) : longint'(ua);
    sb = ((ub >> (W-1)) != 0) ? longint'(ub) - (longint'(1) << W) : longint'(ub);
    case (o)
      C_ADD: begin t = ua + ub; cy = (t >> W) != 0; t = t & MASK; end
      C_SUB: begin t = (ua - ub) & MASK; cy = ua < ub; end
      C_ABS: begin
        mag = (sb < 0) ? longint'(-sb) : longint'(sb);
        t = (ua + mag) & MASK;
        ovf = (sb == -(longint'(1) << (W-1)));
      end
      C_MUL: begin
        prod = {{W{1'b0}}, av} * {{W{1'b0}}, bv};
        t = prod[W-1:0];
        ovf = prod[2*W-1:W] != 0;
      end
      C_DIV: begin
        if (ub == 0) begin t = MASK; err = 1; end
        else t = ua / ub;
      end
      C_SHL: t = (ua << sh) & MASK;
      C_SHR: t = ua >> sh;
      C_SRA: t = longint'(sa >>> sh) & MASK;
      default: begin t = 0; err = 1; end
    endcase
    r = t[W-1:0];
    f = {err, ovf, cy, (r == '0)};
  endfunction

  // Issue one command with the consumer always ready, then check timing and the result.
  task automatic run_op(input string name, input logic [4:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [SW-1:0] sh, input logic [W-1:0] er, input logic [3:0] ef, input int elat);
    int n;
    bit rdy_seen;
    logic [W-1:0] xr;
    logic [3:0]   xf;
    exp_q.push_back(er);
    exp_f_q.push_back(ef);
    out_ready = 1'b1;
    op = o; a = av; b = bv; shamt = sh; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    check({name, " accept wait"}, n, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'({$urandom(), $urandom()});
    b = W'({$urandom(), $urandom()});
    op = 5'($urandom_range(0, 31));
    shamt = SW'($urandom_range(0, 63));
    n = 0;
    rdy_seen = 0;
    while (!out_valid && n < 200) begin
      if (in_ready) rdy_seen = 1;
      @(posedge clk); #1; n++;
    end
    check({name, " latency"}, n, elat);
    if (elat > 0) check({name, " in_ready busy"}, rdy_seen, 0);
    xr = exp_q.pop_front();
    xf = exp_f_q.pop_front();
    check({name, " result"}, result, xr);
    check({name, " flags"}, flags, xf);
  endtask

  initial begin
    logic [4:0]   ops[8];
    logic [4:0]   o;
    logic [W-1:0] av, bv, er;
    logic [SW-1:0] sh;
    logic [3:0]   ef;
    int           cnt;

    tbl[0]  = '{C_ADD, 40'h0B, 40'h03, 6'd0, 40'h0E, 4'b0000, 0};
    tbl[1]  = '{C_SUB, 40'h0B, 40'h03, 6'd0, 40'h08, 4'b0000, 0};
    tbl[2]  = '{C_SUB, 40'h03, 40'h0B, 6'd0, 40'hFFFFFFFFF8, 4'b0010, 0};
    tbl[3]  = '{C_ABS, 40'h0B, 40'hFFFFFFFFFD, 6'd0, 40'h0E, 4'b0000, 0};
    tbl[4]  = '{C_ABS, 40'h0B, 40'h8000000000, 6'd0, 40'h800000000B, 4'b0100, 0};
    tbl[5]  = '{C_MUL, 40'h0B, 40'h03, 6'd0, 40'h21, 4'b0000, W};
    tbl[6]  = '{C_DIV, 40'h0B, 40'h03, 6'd0, 40'h03, 4'b0000, W};
    tbl[7]  = '{C_DIV, 40'h0B, 40'h00, 6'd0, 40'hFFFFFFFFFF, 4'b1000, 0};
    tbl[8]  = '{C_SHL, 40'h0B, 40'h00, 6'd2, 40'h2C, 4'b0000, 0};
    tbl[9]  = '{C_SHR, 40'h0B, 40'h00, 6'd2, 40'h02, 4'b0000, 0};
    tbl[10] = '{C_SRA, 40'h8000000000, 40'h00, 6'd4, 40'hF800000000, 4'b0000, 0};
    tbl[11] = '{5'b11111, 40'h0B, 40'h03, 6'd0, 40'h00, 4'b1001, 0};
    tbl[12] = '{C_ADD, 40'hFFFFFFFFFF, 40'h01, 6'd0, 40'h00, 4'b0011, 0};
    tbl[13] = '{C_MUL, 40'h8000000000, 40'h02, 6'd0, 40'h00, 4'b0101, W};
    tbl[14] = '{C_SUB, 40'h05, 40'h05, 6'd0, 40'h00, 4'b0001, 0};
    tbl[15] = '{C_SHL, 40'h01, 40'h00, 6'd39, 40'h8000000000, 4'b0000, 0};
    tbl[16] = '{C_DIV, 40'hFFFFFFFFFF, 40'h01, 6'd0, 40'hFFFFFFFFFF, 4'b0000, W};
    tbl[17] = '{C_SRA, 40'h8000000000, 40'h00, 6'd63, 40'hFFFFFFFFFF, 4'b0000, 0};
    ops = '{C_ADD, C_ABS, C_SUB, C_MUL, C_DIV, C_SHL, C_SHR, C_SRA};

    // Reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset out_valid", out_valid, 0);
    check("reset result", result, 0);
    check("reset flags", flags, 0);
    check("reset in_ready", in_ready, 1);
    check("reset state", dbg_state, alu_pkg::IDLE);

    for (int i = 0; i < 18; i++)
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh, tbl[i].r, tbl[i].f, tbl[i].lat);

    // Back-pressure: result must hold and no second command may enter.
    @(posedge clk); #1;
    check("drain out_valid", out_valid, 0);
    out_ready = 1'b0;
    op = C_ADD; a = 40'h05; b = 40'h06; in_valid = 1'b1;
    @(posedge clk); #1;
    op = C_SUB; a = 40'h09; b = 40'h01;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d out_valid", i), out_valid, 1);
      check($sformatf("bp%0d result", i), result, 40'h0B);
      check($sformatf("bp%0d flags", i), flags, 4'b0000);
      check($sformatf("bp%0d in_ready", i), in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release no duplicate", out_valid, 0);
    check("bp release in_ready", in_ready, 1);

    // Reset in the middle of a multiply.
    op = C_MUL; a = 40'h0B; b = 40'h03; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid-mul in_ready", in_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid-reset out_valid", out_valid, 0);
    check("mid-reset result", result, 0);
    check("mid-reset flags", flags, 0);
    check("mid-reset in_ready", in_ready, 1);
    cnt = 0;
    repeat (45) begin
      if (out_valid) cnt++;
      @(posedge clk); #1;
    end
    check("discarded mul", cnt, 0);
    run_op("post-reset add", C_ADD, 40'h0B, 40'h03, 6'd0, 40'h0E, 4'b0000, 0);

    // Random commands against the model.
    for (int i = 0; i < 60; i++) begin
      o = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : ops[$urandom_range(0, 7)];
      av = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'({$urandom(), $urandom()});
      case ($urandom_range(0, 5))
        0:       bv = '0;
        1, 2:    bv = W'($urandom_range(1, 15));
        default: bv = W'({$urandom(), $urandom()});
      endcase
      sh = SW'($urandom_range(0, 63));
      model(o, av, bv, sh, er, ef);
      run_op($sformatf("rand%0d op%0h", i, o), o, av, bv, sh, er, ef,
             ((o == C_MUL) || ((o == C_DIV) && (bv != '0))) ? W : 0);
    end

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
